// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the I-cache (read-only) and the D-cache (read/write).
// Collisions are resolved round-robin; each completion returns as a one-cycle registered ready pulse.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       cnt_i_grant,
    output logic [15:0]       cnt_d_grant,
    output logic [15:0]       cnt_busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {SIDE_I, SIDE_D} side_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t            state_q, state_d;
    side_t             owner_q, owner_d;
    side_t             last_q, last_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [15:0]       cnt_i_q, cnt_i_d;
    logic [15:0]       cnt_d_q, cnt_d_d;
    logic [15:0]       cnt_busy_q, cnt_busy_d;
    logic              grant_i, grant_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

    // On a collision the side that was not granted last wins.
    always_comb begin
        grant_d = (d_read | d_write) && (!i_read || last_q == SIDE_I);
        grant_i = i_read && !grant_d;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        cnt_i_d     = cnt_i_q;
        cnt_d_d     = cnt_d_q;
        cnt_busy_d  = cnt_busy_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    mem_addr_d  = i_addr;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    owner_d     = SIDE_I;
                    last_d      = SIDE_I;
                    cnt_i_d     = sat_inc(cnt_i_q);
                    state_d     = BUSY;
                end else if (grant_d) begin
                    // A write-back wins over a read when both are raised together.
                    mem_addr_d  = d_addr;
                    mem_read_d  = !d_write;
                    mem_write_d = d_write;
                    if (d_write) mem_wdata_d = d_wdata;
                    owner_d     = SIDE_D;
                    last_d      = SIDE_D;
                    cnt_d_d     = sat_inc(cnt_d_q);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                cnt_busy_d = sat_inc(cnt_busy_q);
                if (mem_ready) begin
                    if (mem_read_q) begin
                        if (owner_q == SIDE_I) i_rdata_d = mem_rdata;
                        else                   d_rdata_d = mem_rdata;
                    end
                    i_ready_d   = (owner_q == SIDE_I);
                    d_ready_d   = (owner_q == SIDE_D);
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= SIDE_I;
            last_q      <= SIDE_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            cnt_i_q     <= '0;
            cnt_d_q     <= '0;
            cnt_busy_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            cnt_i_q     <= cnt_i_d;
            cnt_d_q     <= cnt_d_d;
            cnt_busy_q  <= cnt_busy_d;
        end
    end

    assign i_rdata     = i_rdata_q;
    assign i_ready     = i_ready_q;
    assign d_rdata     = d_rdata_q;
    assign d_ready     = d_ready_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cnt_i_grant = cnt_i_q;
    assign cnt_d_grant = cnt_d_q;
    assign cnt_busy    = cnt_busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model predicts each grant from the sampled requests,
// pushes the expected completion, and a separate monitor pops it on every ready pulse.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    typedef struct packed {
        logic          side;   // 0 = I, 1 = D
        logic          rd;
        logic [DW-1:0] data;
    } resp_t;

    logic          clk, rst;
    logic          i_read, i_ready, d_read, d_write, d_ready;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic          mem_read, mem_write, mem_ready;
    logic [15:0]   cnt_i_grant, cnt_d_grant, cnt_busy;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant), .cnt_busy(cnt_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus configuration (written by the main process only)
    int            lat_fixed, rdy_len, pulse_req, i_gap, d_gap;
    logic          rnd_lat, use_fixed;
    logic [DW-1:0] fixed_data;

    // Reference model state (memory/grant process)
    logic          last_side;
    int            exp_cnt_i, exp_cnt_d, busy_cycles;
    logic [DW-1:0] exp_wdata;
    resp_t         resp_q[$];

    // Monitor state
    logic [DW-1:0] exp_i_rdata, exp_d_rdata;
    int            n_i_rdy, n_d_rdy;

    // Requests as the DUT saw them at the last rising edge
    logic          s_i, s_d, s_dw;
    logic [AW-1:0] s_ia, s_da;
    logic [DW-1:0] s_wd;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [DW-1:0] sat16(input int v);
        return (v > 65535) ? DW'(65535) : DW'(v);
    endfunction

    initial begin
        s_i = 0; s_d = 0; s_dw = 0; s_ia = '0; s_da = '0; s_wd = '0;
        forever begin
            @(posedge clk);
            s_i  = i_read;
            s_d  = d_read | d_write;
            s_dw = d_write;
            s_ia = i_addr;
            s_da = d_addr;
            s_wd = d_wdata;
        end
    end

    // Memory model + grant predictor: round-robin on collisions, write beats read on D.
    initial begin
        int            wait_cnt, cur_lat, rdy_left, pulse_done;
        logic          prev_strobe, strobe, side, rd;
        logic [AW-1:0] cur_addr;
        mem_ready = 1'b0; mem_rdata = '0;
        wait_cnt = 0; cur_lat = 1; rdy_left = 0; pulse_done = 0;
        prev_strobe = 0; strobe = 0; side = 0; rd = 1; cur_addr = '0;
        last_side = 0; exp_cnt_i = 0; exp_cnt_d = 0; busy_cycles = 0; exp_wdata = '0;
        forever begin
            @(negedge clk);
            strobe = mem_read | mem_write;
            if (rst) begin
                last_side = 0; exp_cnt_i = 0; exp_cnt_d = 0; busy_cycles = 0; exp_wdata = '0;
                mem_ready = 0; rdy_left = 0; wait_cnt = 0; prev_strobe = 0;
                pulse_done = pulse_req;
            end else begin
                if (strobe && !prev_strobe) begin
                    check("grant_has_request", DW'(s_i | s_d), DW'(1));
                    side = (s_i && s_d) ? !last_side : s_d;
                    last_side = side;
                    if (!side) begin
                        rd = 1; cur_addr = s_ia; exp_cnt_i++;
                    end else begin
                        rd = !s_dw; cur_addr = s_da; exp_cnt_d++;
                        if (s_dw) exp_wdata = s_wd;
                    end
                    wait_cnt = 0;
                    cur_lat = rnd_lat ? int'($urandom_range(1, 6)) : lat_fixed;
                end
                if (strobe) begin
                    check("mem_read", DW'(mem_read), DW'(rd));
                    check("mem_write", DW'(mem_write), DW'(!rd));
                    check("mem_addr", DW'(mem_addr), DW'(cur_addr));
                    check("mem_wdata", mem_wdata, exp_wdata);
                    busy_cycles++;
                end
                if (rdy_left > 0) begin
                    rdy_left--;
                    if (rdy_left == 0) mem_ready = 0;
                end else if (pulse_done != pulse_req) begin
                    pulse_done = pulse_req;
                    mem_ready = 1; mem_rdata = rnd128(); rdy_left = 1;
                end else if (strobe) begin
                    if (wait_cnt + 1 >= cur_lat) begin
                        mem_ready = 1;
                        mem_rdata = use_fixed ? fixed_data : rnd128();
                        rdy_left = rdy_len;
                        resp_q.push_back('{side: side, rd: rd, data: mem_rdata});
                    end else wait_cnt++;
                end
                prev_strobe = strobe;
            end
        end
    end

    // Completion monitor
    initial begin
        resp_t r;
        logic  have, prev_rdy;
        prev_rdy = 0; exp_i_rdata = '0; exp_d_rdata = '0; n_i_rdy = 0; n_d_rdy = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                resp_q.delete();
                exp_i_rdata = '0; exp_d_rdata = '0; n_i_rdy = 0; n_d_rdy = 0; prev_rdy = 0;
            end else begin
                if (i_ready || d_ready) begin
                    check("ready_exclusive", DW'(i_ready & d_ready), DW'(0));
                    check("ready_single_cycle", DW'(prev_rdy), DW'(0));
                    check("strobes_low_in_done", DW'(mem_read | mem_write), DW'(0));
                    have = (resp_q.size() != 0);
                    check("ready_has_txn", DW'(have), DW'(1));
                    if (have) begin
                        r = resp_q.pop_front();
                        check("ready_side", DW'(d_ready), DW'(r.side));
                        if (r.side) n_d_rdy++; else n_i_rdy++;
                        if (r.rd) begin
                            if (r.side) exp_d_rdata = r.data;
                            else        exp_i_rdata = r.data;
                        end
                    end
                end
                check("i_rdata", i_rdata, exp_i_rdata);
                check("d_rdata", d_rdata, exp_d_rdata);
                prev_rdy = i_ready | d_ready;
            end
        end
    end

    // One cycle of requester behaviour: drop on ready, optionally raise new random requests.
    task automatic tick(input logic rnd);
        int k;
        @(negedge clk);
        if (i_ready) i_read = 0;
        else if (rnd && !i_read) begin
            if (i_gap > 0) i_gap--;
            else begin
                i_read = 1; i_addr = AW'($urandom()); i_gap = $urandom_range(0, 4);
            end
        end
        if (d_ready) begin
            d_read = 0; d_write = 0;
        end else if (rnd && !d_read && !d_write) begin
            if (d_gap > 0) d_gap--;
            else begin
                k = $urandom_range(0, 2);
                d_read = (k != 1); d_write = (k != 0);
                d_addr = AW'($urandom()); d_wdata = rnd128(); d_gap = $urandom_range(0, 4);
            end
        end
        if (rnd) rdy_len = $urandom_range(1, 3);
    endtask

    task automatic wait_quiet(input string name);
        int   q;
        logic ok;
        q = 0; ok = 0;
        for (int k = 0; k < 3000; k++) begin
            tick(1'b0);
            if (!i_read && !d_read && !d_write && !mem_read && !mem_write &&
                !mem_ready && !i_ready && !d_ready) q++;
            else q = 0;
            if (q >= 2) begin ok = 1; break; end
        end
        check({name, "_completes"}, DW'(ok), DW'(1));
    endtask

    task automatic check_counters(input string name);
        check({name, "_cnt_i"}, DW'(cnt_i_grant), DW'(exp_cnt_i));
        check({name, "_cnt_d"}, DW'(cnt_d_grant), DW'(exp_cnt_d));
        check({name, "_cnt_busy"}, DW'(cnt_busy), sat16(busy_cycles));
        check({name, "_i_done"}, DW'(n_i_rdy), DW'(exp_cnt_i));
        check({name, "_d_done"}, DW'(n_d_rdy), DW'(exp_cnt_d));
    endtask

    initial begin
        int            nstb;
        logic          ok;
        logic [DW-1:0] keep;
        rst = 1; i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        lat_fixed = 1; rdy_len = 1; pulse_req = 0; i_gap = 0; d_gap = 0;
        rnd_lat = 0; use_fixed = 0; fixed_data = '0;
        repeat (3) @(negedge clk);
        check("rst_i_ready", DW'(i_ready), DW'(0));
        check("rst_d_ready", DW'(d_ready), DW'(0));
        check("rst_mem_read", DW'(mem_read), DW'(0));
        check("rst_mem_write", DW'(mem_write), DW'(0));
        check("rst_mem_addr", DW'(mem_addr), DW'(0));
        check("rst_mem_wdata", mem_wdata, DW'(0));
        check("rst_cnt_i", DW'(cnt_i_grant), DW'(0));
        check("rst_cnt_d", DW'(cnt_d_grant), DW'(0));
        check("rst_cnt_busy", DW'(cnt_busy), DW'(0));
        rst = 0;

        // Single I read, memory answers in the 5th BUSY cycle.
        use_fixed = 1; fixed_data = {32{4'hA}}; lat_fixed = 5;
        i_addr = 28'h10; i_read = 1;
        tick(1'b0);
        check("i_grant_latency", DW'(mem_read), DW'(1));
        nstb = mem_read ? 1 : 0; ok = 0;
        for (int k = 0; k < 50; k++) begin
            tick(1'b0);
            if (i_ready) begin ok = 1; break; end
            if (mem_read) nstb++;
        end
        check("i_read_completes", DW'(ok), DW'(1));
        check("i_read_strobe_cycles", DW'(nstb), DW'(5));
        check("i_read_rdata", i_rdata, {32{4'hA}});
        check("i_read_cnt_i", DW'(cnt_i_grant), DW'(1));
        check("i_read_cnt_busy", DW'(cnt_busy), DW'(5));
        tick(1'b0);
        check("i_ready_pulse_width", DW'(i_ready), DW'(0));
        use_fixed = 0;

        // Two collision rounds: each expected to grant D then I.
        lat_fixed = 2;
        for (int r = 0; r < 2; r++) begin
            tick(1'b0);
            i_addr = AW'($urandom()); i_read = 1;
            d_addr = AW'($urandom()); d_wdata = rnd128(); d_write = 1;
            wait_quiet("collision");
        end
        check("collision_cnt_i", DW'(cnt_i_grant), DW'(3));
        check("collision_cnt_d", DW'(cnt_d_grant), DW'(2));

        // D read, then read+write together must act as a write and leave d_rdata alone.
        tick(1'b0);
        d_addr = 28'h55; d_read = 1;
        wait_quiet("d_read");
        keep = exp_d_rdata;
        tick(1'b0);
        d_addr = 28'h66; d_wdata = rnd128(); d_read = 1; d_write = 1;
        wait_quiet("d_rw_both");
        check("d_rw_rdata_kept", d_rdata, keep);
        check_counters("directed");

        // Reset two cycles into BUSY aborts the transaction with no ready pulse.
        lat_fixed = 20;
        i_addr = 28'h123; i_read = 1;
        tick(1'b0); tick(1'b0);
        check("abort_in_busy", DW'(mem_read), DW'(1));
        rst = 1; i_read = 0;
        tick(1'b0);
        check("abort_mem_read", DW'(mem_read), DW'(0));
        check("abort_mem_write", DW'(mem_write), DW'(0));
        check("abort_no_ready", DW'(i_ready | d_ready), DW'(0));
        check("abort_cnt_i", DW'(cnt_i_grant), DW'(0));
        check("abort_cnt_busy", DW'(cnt_busy), DW'(0));
        check("abort_mem_addr", DW'(mem_addr), DW'(0));
        tick(1'b0);
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0);
            check("post_abort_no_ready", DW'(i_ready | d_ready), DW'(0));
        end
        lat_fixed = 3;
        i_addr = 28'h200; i_read = 1; d_addr = 28'h300; d_read = 1;
        wait_quiet("post_abort");
        check("post_abort_cnt_i", DW'(cnt_i_grant), DW'(1));
        check("post_abort_cnt_d", DW'(cnt_d_grant), DW'(1));
        check("post_abort_cnt_busy", DW'(cnt_busy), DW'(6));

        // Stray mem_ready in IDLE, and mem_ready held through DONE/IDLE.
        pulse_req++;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0);
            check("stray_no_ready", DW'(i_ready | d_ready), DW'(0));
            check("stray_no_strobe", DW'(mem_read | mem_write), DW'(0));
        end
        check("stray_cnt_busy", DW'(cnt_busy), DW'(6));
        rdy_len = 3; lat_fixed = 1;
        i_addr = 28'h400; i_read = 1;
        wait_quiet("held_ready");
        rdy_len = 1;
        check_counters("stray");

        // Randomised traffic with random latency and ready lengths.
        rnd_lat = 1;
        for (int k = 0; k < 1500; k++) tick(1'b1);
        rnd_lat = 0; rdy_len = 1; lat_fixed = 2;
        wait_quiet("random");
        check_counters("random");

        // Long stall pushes cnt_busy into saturation.
        lat_fixed = 66000;
        d_addr = 28'h777; d_read = 1; d_write = 0; ok = 0;
        for (int k = 0; k < 70000; k++) begin
            tick(1'b0);
            if (d_ready) begin ok = 1; break; end
        end
        check("stall_completes", DW'(ok), DW'(1));
        check("cnt_busy_saturated", DW'(cnt_busy), DW'(16'hFFFF));
        lat_fixed = 2;
        wait_quiet("after_stall");
        i_addr = 28'h888; i_read = 1;
        wait_quiet("post_sat");
        check("cnt_busy_no_wrap", DW'(cnt_busy), DW'(16'hFFFF));
        check_counters("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
